button_event_queue: RTL and testbench

//  Upstream input stage for the CPU I/O port at 0xF000.
//  - Synchronises and debounces the physical buttons.
//  - Turns each clean press (rising edge) into a button-mask event and queues it in a show-ahead FIFO.
//  - The CPU pops events through the system bus read strobe.
//  - The 4-bit head entry is zero-extended to 16 bits in the system bus.

---
 rtl/button_event_queue.sv | 179 +++++++++++++++++
 tb/tb_button_event_queue.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_queue.sv
// Button front end for the CPU I/O port: synchronise, debounce, turn presses into
// button-mask events and queue them in a show-ahead FIFO that the CPU pops.
module button_event_queue #(
    parameter int NUM_BTN         = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic               sys_clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] buttons_in,
    input  logic               cpu_read_en,
    output logic [NUM_BTN-1:0] data_to_cpu,
    output logic               fifo_empty,
    output logic               fifo_full,
    output logic               overflow
);

    localparam int CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int COUNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_RELEASED     = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    // ---------------------------------------------------------------
    // Metastability synchroniser: stage 0 samples the raw pins
    // ---------------------------------------------------------------
    logic [SYNC_STAGES-1:0][NUM_BTN-1:0] r_sync;
    logic [NUM_BTN-1:0]                  w_sync;

    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], buttons_in};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // ---------------------------------------------------------------
    // Per-button debounce FSM
    // ---------------------------------------------------------------
    logic [NUM_BTN-1:0] w_pulse;

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        logic [1:0]       r_state;
        logic [CNT_W-1:0] r_cnt;
        logic             w_s;

        assign w_s = w_sync[b];

        // The pulse fires in the same cycle the FSM commits to PRESSED.
        assign w_pulse[b] = (r_state == ST_PRESS_WAIT) && w_s && (r_cnt == CNT_LAST);

        always_ff @(posedge sys_clock or negedge reset) begin
            if (!reset) begin
                r_state <= ST_RELEASED;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    ST_RELEASED: begin
                        if (w_s) begin
                            r_state <= ST_PRESS_WAIT;
                            r_cnt   <= CNT_W'(1);
                        end
                    end
                    ST_PRESS_WAIT: begin
                        if (!w_s) begin
                            r_state <= ST_RELEASED;
                            r_cnt   <= '0;
                        end else if (r_cnt == CNT_LAST) begin
                            r_state <= ST_PRESSED;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    ST_PRESSED: begin
                        if (!w_s) begin
                            r_state <= ST_RELEASE_WAIT;
                            r_cnt   <= CNT_W'(1);
                        end
                    end
                    ST_RELEASE_WAIT: begin
                        if (w_s) begin
                            r_state <= ST_PRESSED;
                            r_cnt   <= '0;
                        end else if (r_cnt == CNT_LAST) begin
                            r_state <= ST_RELEASED;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_RELEASED;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // ---------------------------------------------------------------
    // Event formation and show-ahead FIFO
    // ---------------------------------------------------------------
    logic [NUM_BTN-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [COUNT_W-1:0] r_count;
    logic               r_empty;
    logic               r_full;
    logic               r_overflow;

    logic               w_event;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [COUNT_W-1:0] w_count_nxt;

    assign w_event = |w_pulse;
    assign w_pop   = cpu_read_en && !r_empty;
    // A pop on the same edge frees the slot a full queue needs.
    assign w_push  = w_event && (!r_full || w_pop);
    assign w_drop  = w_event && r_full && !w_pop;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + COUNT_W'(1);
            2'b01:   w_count_nxt = r_count - COUNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == COUNT_FULL);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage carries data only; validity is tracked by the pointers and count.
    always_ff @(posedge sys_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_pulse;
        end
    end

    assign data_to_cpu = r_empty ? '0 : r_mem[r_rd_ptr];
    assign fifo_empty  = r_empty;
    assign fifo_full   = r_full;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_button_event_queue.sv
// Scoreboard bench for button_event_queue with a short debounce and a 4-entry queue.
module tb_button_event_queue;

    logic       sys_clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] buttons_in = 4'b0000;
    logic       cpu_read_en = 1'b0;
    logic [3:0] data_to_cpu;
    logic       fifo_empty;
    logic       fifo_full;
    logic       overflow;

    int         n_pass = 0;
    int         n_total = 0;
    logic [3:0] sb[$];

    button_event_queue #(
        .NUM_BTN        (4),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .FIFO_DEPTH     (4)
    ) dut (
        .sys_clock  (sys_clock),
        .reset      (reset),
        .buttons_in (buttons_in),
        .cpu_read_en(cpu_read_en),
        .data_to_cpu(data_to_cpu),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .overflow   (overflow)
    );

    always #5 sys_clock = ~sys_clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clock);
            #1;
        end
    endtask

    task automatic pop_entry(output logic [3:0] d);
        d = data_to_cpu;
        cpu_read_en = 1'b1;
        tick(1);
        cpu_read_en = 1'b0;
    endtask

    task automatic press_release(input logic [3:0] m);
        buttons_in = m;
        tick(8);
        buttons_in = 4'b0000;
        tick(8);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        sb.delete();
        tick(3);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        tick(2);
        n_total++; if (data_to_cpu !== 4'b0000) $display("FAIL reset_data: got %b want 0000", data_to_cpu); else n_pass++;
        n_total++; if (fifo_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", fifo_empty); else n_pass++;
        n_total++; if (fifo_full !== 1'b0) $display("FAIL reset_full: got %b want 0", fifo_full); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
        reset = 1'b1;
        tick(4);
        n_total++; if (fifo_empty !== 1'b1) $display("FAIL reset_idle_empty: got %b want 1", fifo_empty); else n_pass++;
    endtask

    task automatic test_single_press();
        logic [3:0] d;
        logic [3:0] exp;
        buttons_in = 4'b0001;
        sb.push_back(4'b0001);
        tick(5);
        n_total++; if (fifo_empty !== 1'b1) $display("FAIL t1_early: empty got %b want 1", fifo_empty); else n_pass++;
        tick(1);
        n_total++; if (fifo_empty !== 1'b0) $display("FAIL t1_latency: empty got %b want 0", fifo_empty); else n_pass++;
        n_total++; if (data_to_cpu !== sb[0]) $display("FAIL t1_head: got %b want %b", data_to_cpu, sb[0]); else n_pass++;
        tick(14);
        pop_entry(d);
        exp = sb.pop_front();
        n_total++; if (d !== exp) $display("FAIL t1_pop: got %b want %b", d, exp); else n_pass++;
        n_total++; if (data_to_cpu !== 4'b0000) $display("FAIL t1_data_after_pop: got %b want 0000", data_to_cpu); else n_pass++;
        n_total++; if (fifo_empty !== 1'b1) $display("FAIL t1_empty_after_pop: got %b want 1", fifo_empty); else n_pass++;
        buttons_in = 4'b0000;
        tick(10);
        n_total++; if (fifo_empty !== 1'b1) $display("FAIL t1_release: empty got %b want 1", fifo_empty); else n_pass++;
    endtask

    task automatic test_bounce();
        logic [3:0] d;
        logic [3:0] exp;
        for (int i = 0; i < 3; i++) begin
            buttons_in = 4'b0010;
            tick(2);
            buttons_in = 4'b0000;
            tick(2);
        end
        tick(2);
        n_total++; if (fifo_empty !== 1'b1) $display("FAIL t2_bounce: empty got %b want 1", fifo_empty); else n_pass++;
        buttons_in = 4'b0010;
        sb.push_back(4'b0010);
        tick(20);
        pop_entry(d);
        exp = sb.pop_front();
        n_total++; if (d !== exp) $display("FAIL t2_pop: got %b want %b", d, exp); else n_pass++;
        n_total++; if (fifo_empty !== 1'b1) $display("FAIL t2_single: empty got %b want 1", fifo_empty); else n_pass++;
        buttons_in = 4'b0000;
        tick(12);
        n_total++; if (fifo_empty !== 1'b1) $display("FAIL t2_release: empty got %b want 1", fifo_empty); else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [3:0] d;
        logic [3:0] exp;
        buttons_in = 4'b1001;
        sb.push_back(4'b1001);
        tick(6);
        n_total++; if (data_to_cpu !== sb[0]) $display("FAIL t3_head: got %b want %b", data_to_cpu, sb[0]); else n_pass++;
        n_total++; if (fifo_full !== 1'b0) $display("FAIL t3_full: got %b want 0", fifo_full); else n_pass++;
        pop_entry(d);
        exp = sb.pop_front();
        n_total++; if (d !== exp) $display("FAIL t3_pop: got %b want %b", d, exp); else n_pass++;
        n_total++; if (fifo_empty !== 1'b1) $display("FAIL t3_one_entry: empty got %b want 1", fifo_empty); else n_pass++;
        buttons_in = 4'b0000;
        tick(10);
    endtask

    task automatic test_empty_pop();
        logic [3:0] d;
        logic [3:0] exp;
        cpu_read_en = 1'b1;
        buttons_in = 4'b0100;
        sb.push_back(4'b0100);
        tick(6);
        cpu_read_en = 1'b0;
        n_total++; if (fifo_empty !== 1'b0) $display("FAIL te_push_while_read: empty got %b want 0", fifo_empty); else n_pass++;
        n_total++; if (data_to_cpu !== sb[0]) $display("FAIL te_head: got %b want %b", data_to_cpu, sb[0]); else n_pass++;
        pop_entry(d);
        exp = sb.pop_front();
        n_total++; if (d !== exp) $display("FAIL te_pop: got %b want %b", d, exp); else n_pass++;
        n_total++; if (fifo_empty !== 1'b1) $display("FAIL te_empty: got %b want 1", fifo_empty); else n_pass++;
        buttons_in = 4'b0000;
        tick(10);
    endtask

    task automatic test_overflow();
        logic [3:0] masks [5];
        logic [3:0] d;
        logic [3:0] exp;
        masks = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            if (sb.size() < 4) sb.push_back(masks[i]);
            press_release(masks[i]);
            if (i == 3) begin
                n_total++; if (fifo_full !== 1'b1) $display("FAIL t4_full_at_4: got %b want 1", fifo_full); else n_pass++;
                n_total++; if (overflow !== 1'b0) $display("FAIL t4_no_ovf_at_4: got %b want 0", overflow); else n_pass++;
            end
        end
        n_total++; if (overflow !== 1'b1) $display("FAIL t4_overflow: got %b want 1", overflow); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            pop_entry(d);
            exp = sb.pop_front();
            n_total++; if (d !== exp) $display("FAIL t4_order%0d: got %b want %b", i, d, exp); else n_pass++;
        end
        n_total++; if (data_to_cpu !== 4'b0000) $display("FAIL t4_drained_data: got %b want 0000", data_to_cpu); else n_pass++;
        n_total++; if (fifo_empty !== 1'b1) $display("FAIL t4_drained_empty: got %b want 1", fifo_empty); else n_pass++;
        n_total++; if (overflow !== 1'b1) $display("FAIL t4_ovf_sticky: got %b want 1", overflow); else n_pass++;
    endtask

    task automatic test_full_push_pop();
        logic [3:0] masks [4];
        logic [3:0] d;
        logic [3:0] exp;
        apply_reset();
        n_total++; if (overflow !== 1'b0) $display("FAIL t5_ovf_cleared: got %b want 0", overflow); else n_pass++;
        masks = '{4'b0001, 4'b0010, 4'b1000, 4'b0011};
        for (int i = 0; i < 4; i++) begin
            sb.push_back(masks[i]);
            press_release(masks[i]);
        end
        n_total++; if (fifo_full !== 1'b1) $display("FAIL t5_full: got %b want 1", fifo_full); else n_pass++;
        buttons_in = 4'b0100;
        sb.push_back(4'b0100);
        tick(5);
        d = data_to_cpu;
        cpu_read_en = 1'b1;
        tick(1);
        cpu_read_en = 1'b0;
        exp = sb.pop_front();
        n_total++; if (d !== exp) $display("FAIL t5_pop_head: got %b want %b", d, exp); else n_pass++;
        n_total++; if (fifo_full !== 1'b1) $display("FAIL t5_still_full: got %b want 1", fifo_full); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL t5_no_ovf: got %b want 0", overflow); else n_pass++;
        buttons_in = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            pop_entry(d);
            exp = sb.pop_front();
            n_total++; if (d !== exp) $display("FAIL t5_order%0d: got %b want %b", i, d, exp); else n_pass++;
        end
        n_total++; if (fifo_empty !== 1'b1) $display("FAIL t5_empty: got %b want 1", fifo_empty); else n_pass++;
        tick(10);
    endtask

    task automatic test_reset_midway();
        logic [3:0] d;
        logic [3:0] exp;
        sb.push_back(4'b0001);
        press_release(4'b0001);
        sb.push_back(4'b0010);
        press_release(4'b0010);
        n_total++; if (data_to_cpu !== sb[0]) $display("FAIL t6_pre_head: got %b want %b", data_to_cpu, sb[0]); else n_pass++;
        buttons_in = 4'b0100;
        tick(3);
        #2;
        reset = 1'b0;
        sb.delete();
        #1;
        n_total++; if (data_to_cpu !== 4'b0000) $display("FAIL t6_async_data: got %b want 0000", data_to_cpu); else n_pass++;
        n_total++; if (fifo_empty !== 1'b1) $display("FAIL t6_async_empty: got %b want 1", fifo_empty); else n_pass++;
        n_total++; if (fifo_full !== 1'b0) $display("FAIL t6_async_full: got %b want 0", fifo_full); else n_pass++;
        tick(3);
        reset = 1'b1;
        sb.push_back(4'b0100);
        tick(5);
        n_total++; if (fifo_empty !== 1'b1) $display("FAIL t6_early: empty got %b want 1", fifo_empty); else n_pass++;
        tick(1);
        n_total++; if (data_to_cpu !== sb[0]) $display("FAIL t6_head: got %b want %b", data_to_cpu, sb[0]); else n_pass++;
        pop_entry(d);
        exp = sb.pop_front();
        n_total++; if (d !== exp) $display("FAIL t6_pop: got %b want %b", d, exp); else n_pass++;
        n_total++; if (fifo_empty !== 1'b1) $display("FAIL t6_discarded: empty got %b want 1", fifo_empty); else n_pass++;
        buttons_in = 4'b0000;
        tick(10);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_simultaneous();
        test_empty_pop();
        test_overflow();
        test_full_push_pop();
        test_reset_midway();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
